// File: rtl/instr_issue.sv
`default_nettype none
// ============================================================================
// Module   : instr_issue
// Brief    : Fetch/issue front end. The block fetches one instruction at a
//            time, presents it to the consumer with a valid/ready handshake,
//            waits for branch/jump resolution when needed, and stops on halt.
// Revision : 1.0 - initial release
// ============================================================================
module instr_issue (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_rdata,
    output logic        issue_valid,
    input  logic        issue_ready,
    output logic [15:0] issue_instr,
    output logic [3:0]  con_opcode,
    output logic [15:0] issue_pc,
    input  logic        res_valid,
    input  logic        res_taken,
    input  logic [15:0] res_target,
    output logic        halted,
    output logic [15:0] issue_count
);

    localparam logic [1:0] c_ST_FETCH   = 2'd0;
    localparam logic [1:0] c_ST_ISSUE   = 2'd1;
    localparam logic [1:0] c_ST_RESOLVE = 2'd2;
    localparam logic [1:0] c_ST_HALT    = 2'd3;

    localparam logic [15:0] c_PC_STEP   = 16'd2;
    localparam logic [15:0] c_COUNT_MAX = 16'hFFFF;

    logic [1:0]  r_state;
    logic [15:0] r_pc;
    logic [15:0] r_instr;
    logic [15:0] r_issue_pc;
    logic [15:0] r_count;

    logic [3:0]  w_opcode;
    logic        w_needs_resolve;

    // Opcode of the held instruction and whether it must wait for resolution
    always_comb begin
        w_opcode        = r_instr[15:12];
        w_needs_resolve = 1'b0;
        case (w_opcode)
            4'b0001, 4'b0100, 4'b0101, 4'b0110: w_needs_resolve = 1'b1;
            default:                            w_needs_resolve = 1'b0;
        endcase
    end

    // Main sequencer: fetch, present, resolve control flow, or halt
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= c_ST_FETCH;
            r_pc       <= 16'h0000;
            r_instr    <= 16'h0000;
            r_issue_pc <= 16'h0000;
            r_count    <= 16'h0000;
        end else begin
            case (r_state)
                c_ST_FETCH: begin
                    if (imem_ack) begin
                        r_instr    <= imem_rdata;
                        r_issue_pc <= r_pc;
                        r_state    <= c_ST_ISSUE;
                    end
                end
                c_ST_ISSUE: begin
                    if (issue_ready) begin
                        // Halt is counted like any other accepted issue
                        if (r_count != c_COUNT_MAX) begin
                            r_count <= r_count + 16'd1;
                        end
                        if (w_opcode == 4'b0000) begin
                            r_state <= c_ST_HALT;
                        end else if (w_needs_resolve) begin
                            r_state <= c_ST_RESOLVE;
                        end else begin
                            r_pc    <= r_pc + c_PC_STEP;
                            r_state <= c_ST_FETCH;
                        end
                    end
                end
                c_ST_RESOLVE: begin
                    if (res_valid) begin
                        // Redirect targets are halfword aligned; bit 0 is dropped
                        if (res_taken) begin
                            r_pc <= {res_target[15:1], 1'b0};
                        end else begin
                            r_pc <= r_issue_pc + c_PC_STEP;
                        end
                        r_state <= c_ST_FETCH;
                    end
                end
                c_ST_HALT: begin
                    r_state <= c_ST_HALT;
                end
                default: begin
                    r_state <= c_ST_FETCH;
                end
            endcase
        end
    end

    // Outputs are decoded purely from registered state
    always_comb begin
        imem_req    = (r_state == c_ST_FETCH);
        imem_addr   = r_pc;
        issue_valid = (r_state == c_ST_ISSUE);
        issue_instr = r_instr;
        con_opcode  = r_instr[15:12];
        issue_pc    = r_issue_pc;
        halted      = (r_state == c_ST_HALT);
        issue_count = r_count;
    end

endmodule
`default_nettype wire

// File: tb/tb_instr_issue.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_issue
// Brief    : Self-checking bench for instr_issue. Acts as instruction memory,
//            consumer and branch resolver, predicting the PC stream per
//            instruction from the architectural rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_issue;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic        issue_valid;
    logic        issue_ready;
    logic [15:0] issue_instr;
    logic [3:0]  con_opcode;
    logic [15:0] issue_pc;
    logic        res_valid;
    logic        res_taken;
    logic [15:0] res_target;
    logic        halted;
    logic [15:0] issue_count;

    int total = 0;
    int bad   = 0;

    // Architectural model state: next fetch address and accepted-issue count
    logic [15:0] exp_pc;
    logic [15:0] exp_count;

    instr_issue dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .issue_valid (issue_valid),
        .issue_ready (issue_ready),
        .issue_instr (issue_instr),
        .con_opcode  (con_opcode),
        .issue_pc    (issue_pc),
        .res_valid   (res_valid),
        .res_taken   (res_taken),
        .res_target  (res_target),
        .halted      (halted),
        .issue_count (issue_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset pulse, optionally with stray ack/resolution that must be dropped
    task automatic do_reset(input logic with_noise);
        reset      = 1'b1;
        imem_ack   = with_noise;
        imem_rdata = 16'hBEEF;
        res_valid  = with_noise;
        res_taken  = 1'b1;
        res_target = 16'h1234;
        issue_ready = with_noise;
        tick();
        reset       = 1'b0;
        imem_ack    = 1'b0;
        res_valid   = 1'b0;
        issue_ready = 1'b0;
        exp_pc    = 16'h0000;
        exp_count = 16'h0000;
        check("rst_req",    imem_req,    1);
        check("rst_addr",   imem_addr,   16'h0000);
        check("rst_valid",  issue_valid, 0);
        check("rst_halted", halted,      0);
        check("rst_count",  issue_count, 16'h0000);
        check("rst_instr",  issue_instr, 16'h0000);
        check("rst_ipc",    issue_pc,    16'h0000);
    endtask

    // One complete instruction: fetch, present, accept, then resolve if needed
    task automatic run_instr(input logic [15:0] word, input int ack_dly, input int stall,
                             input int res_dly, input logic taken, input logic [15:0] target);
        logic [3:0]  op;
        logic        is_ctl;
        logic [15:0] ipc;
        op     = word[15:12];
        is_ctl = (op == 4'd1) || (op == 4'd4) || (op == 4'd5) || (op == 4'd6);
        ipc    = exp_pc;

        check("fetch_req",   imem_req,    1);
        check("fetch_addr",  imem_addr,   exp_pc);
        check("fetch_valid", issue_valid, 0);
        for (int i = 0; i < ack_dly; i++) begin
            issue_ready = 1'($urandom);
            res_valid   = 1'($urandom);
            res_taken   = 1'b1;
            res_target  = 16'($urandom);
            tick();
            check("fetch_wait_req",  imem_req,  1);
            check("fetch_wait_addr", imem_addr, exp_pc);
        end
        issue_ready = 1'b0;
        res_valid   = 1'b0;
        imem_ack    = 1'b1;
        imem_rdata  = word;
        tick();
        imem_ack   = 1'b0;
        imem_rdata = 16'($urandom);

        for (int i = 0; i <= stall; i++) begin
            check("iss_valid",  issue_valid, 1);
            check("iss_instr",  issue_instr, word);
            check("iss_pc",     issue_pc,    ipc);
            check("iss_opcode", con_opcode,  op);
            check("iss_req",    imem_req,    0);
            check("iss_count",  issue_count, exp_count);
            if (i < stall) begin
                issue_ready = 1'b0;
                imem_ack    = 1'($urandom);
                imem_rdata  = 16'($urandom);
                res_valid   = 1'($urandom);
                res_taken   = 1'($urandom);
                res_target  = 16'($urandom);
                tick();
            end
        end
        imem_ack    = 1'b0;
        res_valid   = 1'b0;
        issue_ready = 1'b1;
        tick();
        issue_ready = 1'b0;
        if (exp_count != 16'hFFFF) exp_count = exp_count + 16'd1;
        check("xfer_count", issue_count, exp_count);
        check("xfer_valid", issue_valid, 0);

        if (op == 4'd0) begin
            check("halt_flag", halted,   1);
            check("halt_req",  imem_req, 0);
        end else if (is_ctl) begin
            for (int i = 0; i < res_dly; i++) begin
                imem_ack    = 1'($urandom);
                issue_ready = 1'($urandom);
                res_valid   = 1'b0;
                res_taken   = 1'($urandom);
                res_target  = 16'($urandom);
                tick();
                check("res_wait_req",   imem_req,    0);
                check("res_wait_valid", issue_valid, 0);
            end
            imem_ack    = 1'b0;
            issue_ready = 1'b0;
            res_valid   = 1'b1;
            res_taken   = taken;
            res_target  = target;
            tick();
            res_valid = 1'b0;
            exp_pc = taken ? (target & 16'hFFFE) : ipc + 16'd2;
            check("res_next_req",  imem_req,  1);
            check("res_next_addr", imem_addr, exp_pc);
        end else begin
            exp_pc = ipc + 16'd2;
            check("seq_next_req",  imem_req,  1);
            check("seq_next_addr", imem_addr, exp_pc);
        end
    endtask

    initial begin
        logic [15:0] w;
        reset       = 1'b1;
        imem_ack    = 1'b0;
        imem_rdata  = 16'h0000;
        issue_ready = 1'b0;
        res_valid   = 1'b0;
        res_taken   = 1'b0;
        res_target  = 16'h0000;
        exp_pc      = 16'h0000;
        exp_count   = 16'h0000;
        tick();
        do_reset(1'b0);

        // Sequential stream at full rate
        run_instr(16'hF123, 0, 0, 0, 1'b0, 16'h0);
        run_instr(16'h8045, 0, 0, 0, 1'b0, 16'h0);
        run_instr(16'hC210, 0, 0, 0, 1'b0, 16'h0);
        check("stream_count", issue_count, 16'd3);

        // Back-pressure for five cycles
        run_instr(16'h9001, 1, 5, 0, 1'b0, 16'h0);
        check("bp_count", issue_count, 16'd4);

        // Jump to 0x0010, taken branch there to 0x0041 -> 0x0040
        run_instr(16'h1000, 0, 0, 2, 1'b1, 16'h0010);
        run_instr(16'h5ABC, 0, 0, 1, 1'b1, 16'h0041);
        check("taken_addr", imem_addr, 16'h0040);

        // Jump to 0x0020, not-taken branch there -> 0x0022
        run_instr(16'h1111, 0, 0, 0, 1'b1, 16'h0020);
        run_instr(16'h4DEF, 0, 0, 3, 1'b0, 16'h7770);
        check("nottaken_addr", imem_addr, 16'h0022);

        // Plain jump to 0x0100
        run_instr(16'h1F00, 0, 0, 0, 1'b1, 16'h0100);
        check("jump_addr", imem_addr, 16'h0100);

        // Wrap: jump to 0xFFFF (aligned to 0xFFFE), sequential there -> 0x0000
        run_instr(16'h1222, 0, 0, 0, 1'b1, 16'hFFFF);
        run_instr(16'hF000, 0, 0, 0, 1'b0, 16'h0);
        check("wrap_addr", imem_addr, 16'h0000);

        // Undefined opcodes behave as sequential
        run_instr(16'h2000, 0, 0, 0, 1'b0, 16'h0);
        run_instr(16'h3000, 0, 0, 0, 1'b0, 16'h0);
        run_instr(16'h7000, 0, 0, 0, 1'b0, 16'h0);
        run_instr(16'hE000, 0, 0, 0, 1'b0, 16'h0);

        // Randomized instruction stream
        for (int n = 0; n < 200; n++) begin
            w = 16'($urandom);
            if (w[15:12] == 4'd0) w[15:12] = 4'hA;
            run_instr(w, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                      1'($urandom), 16'($urandom));
        end

        // Halt, then ensure stray strobes are ignored
        run_instr(16'h0000, 0, 2, 0, 1'b0, 16'h0);
        for (int i = 0; i < 6; i++) begin
            imem_ack    = 1'($urandom);
            imem_rdata  = 16'($urandom);
            res_valid   = 1'($urandom);
            res_taken   = 1'($urandom);
            res_target  = 16'($urandom);
            issue_ready = 1'($urandom);
            tick();
            check("halt_hold",  halted,      1);
            check("halt_req0",  imem_req,    0);
            check("halt_vld0",  issue_valid, 0);
            check("halt_count", issue_count, exp_count);
        end
        do_reset(1'b1);

        // Reset in RESOLVE together with a taken resolution
        run_instr(16'h8888, 0, 0, 0, 1'b0, 16'h0);
        imem_ack   = 1'b1;
        imem_rdata = 16'h6000;
        tick();
        imem_ack    = 1'b0;
        issue_ready = 1'b1;
        tick();
        issue_ready = 1'b0;
        check("mid_res_req", imem_req,    0);
        check("mid_res_vld", issue_valid, 0);
        do_reset(1'b1);
        tick();
        check("post_res_req",  imem_req,  1);
        check("post_res_addr", imem_addr, 16'h0000);

        // Reset during a fetch with an ack in the same cycle
        run_instr(16'hB000, 0, 0, 0, 1'b0, 16'h0);
        do_reset(1'b1);
        tick();
        check("post_fetch_vld",  issue_valid, 0);
        check("post_fetch_addr", imem_addr,   16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/instr_issue.md
INSTR_ISSUE -- requirements
Module: instr_issue

Interface
REQ-001 SHALL have the port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 SHALL have the port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have the port imem_req, output, 1 bit: instruction fetch request.
REQ-004 SHALL have the port imem_addr, output, 16 bits: byte address of the fetch (PC).
REQ-005 SHALL have the port imem_ack, input, 1 bit: fetch data valid on imem_rdata this cycle.
REQ-006 SHALL have the port imem_rdata, input, 16 bits: fetched instruction word.
REQ-007 SHALL have the port issue_valid, output, 1 bit: an instruction is presented to the control/datapath.
REQ-008 SHALL have the port issue_ready, input, 1 bit: the consumer accepts the presented instruction.
REQ-009 SHALL have the port issue_instr, output, 16 bits: presented instruction word.
REQ-010 SHALL have the port con_opcode, output, 4 bits: issue_instr[15:12], which drives the control decoder.
REQ-011 SHALL have the port issue_pc, output, 16 bits: address of the presented instruction.
REQ-012 SHALL have the port res_valid, input, 1 bit: branch/jump resolution strobe.
REQ-013 SHALL have the port res_taken, input, 1 bit: resolution outcome.
REQ-014 SHALL have the port res_target, input, 16 bits: redirect address.
REQ-015 SHALL have the port halted, output, 1 bit: halt instruction has been issued.
REQ-016 SHALL have the port issue_count, output, 16 bits: number of accepted issues, saturating.

Function
REQ-017 SHALL implement a four-state FSM: FETCH, ISSUE, RESOLVE and HALT; all outputs SHALL be decoded from registered state only.
REQ-018 FETCH SHALL assert imem_req=1 and imem_addr=pc; when imem_ack=1 it SHALL capture imem_rdata into instr and pc into issue_pc, then go to ISSUE the next cycle. An ack in the same cycle as the request SHALL be legal, and the wait is unbounded.
REQ-019 ISSUE SHALL assert issue_valid=1 with issue_instr and issue_pc stable until accepted.
REQ-020 The transfer rule: issue_valid&&issue_ready completes a transfer; issue_valid SHALL NOT drop before the transfer completes.
REQ-021 On transfer, the next state and PC SHALL be chosen by opcode:
- 0000 (halt): go to HALT; pc is unchanged.
- 0001 (jump), 0100, 0101, 0110 (branches): go to RESOLVE; pc is unchanged.
- all other opcodes, including the undefined 0010, 0011, 0111, 1110: pc<=pc+2 and go to FETCH.
REQ-022 RESOLVE SHALL wait for res_valid=1:
- if res_taken=1: pc<=res_target with bit0 forced to 0.
- otherwise: pc<=issue_pc+2.
- in both cases, go to FETCH.
REQ-023 PC arithmetic SHALL be 16-bit modulo: 16'hFFFE+2 = 16'h0000.
REQ-024 imem_ack SHALL be ignored outside FETCH; res_valid SHALL be ignored outside RESOLVE; issue_ready SHALL be ignored outside ISSUE.
REQ-025 HALT SHALL hold halted=1 with imem_req=0 and issue_valid=0 until reset.
REQ-026 issue_count SHALL increment by 1 per completed transfer, including the halt, and SHALL saturate at 16'hFFFF.
REQ-027 The minimum throughput for sequential code with zero-wait ack and ready tied high SHALL be one instruction per 2 cycles.

Reset
REQ-028 While reset=1 at a clock edge, the block SHALL set: state=FETCH, pc=0, instr=0, issue_pc=0, issue_count=0.
REQ-029 On the cycle after reset, the outputs SHALL be: imem_req=1, imem_addr=0, issue_valid=0, halted=0.
REQ-030 Reset SHALL override every state, including mid-fetch, mid-issue, RESOLVE and HALT; any in-flight ack or resolution arriving in the reset cycle SHALL be discarded.

Verification
REQ-031 The bench SHALL cover a sequential stream: ack every fetch, ready=1, words 16'hF123, 16'h8045, 16'hC210 -> imem_addr sequence 0, 2, 4; con_opcode 1111, 1000, 1100; issue_count=3.
REQ-032 The bench SHALL cover back-pressure: hold issue_ready=0 for 5 cycles on 16'h9001 -> issue_valid, issue_instr and issue_pc stay constant, no new imem_req, and issue_count is unchanged until ready.
REQ-033 The bench SHALL cover a taken branch: issue 16'h5xxx at pc 16'h0010, then res_valid=1, res_taken=1, res_target=16'h0041 -> next imem_addr=16'h0040.
REQ-034 The bench SHALL cover a not-taken branch and a jump:
- 16'h4xxx at 16'h0020 with res_taken=0 -> next imem_addr=16'h0022.
- 16'h1xxx with target 16'h0100 -> next imem_addr=16'h0100.
REQ-035 The bench SHALL cover halt: 16'h0000 accepted -> halted=1, imem_req=0 permanently, and ack/res pulses are ignored; a following reset pulse -> imem_addr=0, halted=0.
REQ-036 The bench SHALL cover wrap and reset mid-operation:
- a sequential instruction at 16'hFFFE -> next imem_addr=16'h0000.
- reset asserted in RESOLVE together with res_valid=1 -> pc=0 and the resolution is ignored.
